arbitro_memoria_imagenes: RTL

Shares the single-port synchronous image memory between the VGA pixel-fetch path and a host update port. The pixel path drives the address produced by the image-position decoder during active video. Host reads and writes run only during blanking through a req/ack handshake. The block sits between the position decoder and the image memory and returns the fetched pixel to the colour mixer.

---
 rtl/arbitro_memoria_imagenes.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/arbitro_memoria_imagenes.sv
// -----------------------------------------------------------------------------
// arbitro_memoria_imagenes
//
// Shares one single-port synchronous image memory between the VGA pixel-fetch
// path and a host update port. During active video the memory address follows
// the image-position decoder. Host reads and writes are granted only during
// blanking through a req/ack handshake. A host access that is already running
// always finishes. Any video cycle it displaces returns a black pixel and is
// counted in a saturating conflict counter.
//
// Ports
//   reloj, resetM       clock (rising edge) / asynchronous active-low reset
//   video_on, dir_vid   active-video flag and pixel address from the decoder
//   dato_vid            pixel to the colour mixer, 0 when not valid
//   vid_valido          video_on delayed to line up with dato_vid (3 cycles)
//   req_w, we_w, dir_w  host request, write/read select, address
//   dato_w              host write data
//   ack_w               one-cycle completion pulse
//   dato_r              host read data, held until the next read completes
//   mem_dir/we/din      registered memory address, write enable, write data
//   mem_dout            memory read data, one cycle after mem_dir
//   conflictos          saturating count of video cycles lost to the host
// -----------------------------------------------------------------------------
module arbitro_memoria_imagenes #(
  parameter int AW = 9,
  parameter int DW = 12
) (
  input  logic          reloj,
  input  logic          resetM,
  input  logic          video_on,
  input  logic [AW-1:0] dir_vid,
  output logic [DW-1:0] dato_vid,
  output logic          vid_valido,
  input  logic          req_w,
  input  logic          we_w,
  input  logic [AW-1:0] dir_w,
  input  logic [DW-1:0] dato_w,
  output logic          ack_w,
  output logic [DW-1:0] dato_r,
  output logic [AW-1:0] mem_dir,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [7:0]    conflictos
);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ESCRIBE  = 2'd1,
    LEE_DIR  = 2'd2,
    LEE_DATO = 2'd3
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [AW-1:0] mem_dir_q, mem_dir_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          ack_w_q, ack_w_d;
  logic [DW-1:0] dato_r_q, dato_r_d;
  logic [DW-1:0] dato_vid_q, dato_vid_d;
  logic          vid_valido_q, vid_valido_d;
  logic [1:0]    v_q, v_d;        // video_on delayed by 1 and 2 cycles
  logic [1:0]    pix_q, pix_d;    // same, but only for slots the video path owned
  logic [7:0]    conflictos_q, conflictos_d;

  logic concede;
  logic conflicto;

  // The ack_w term keeps a host that is still holding req_w in the ack cycle
  // from being granted a second, duplicate access.
  assign concede   = (estado_q == REPOSO) && req_w && !video_on && !ack_w_q;
  assign conflicto = video_on && (estado_q != REPOSO);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    estado_d     = estado_q;
    mem_dir_d    = dir_vid;
    mem_we_d     = 1'b0;
    mem_din_d    = mem_din_q;
    ack_w_d      = 1'b0;
    dato_r_d     = dato_r_q;
    conflictos_d = conflictos_q;

    case (estado_q)
      REPOSO: begin
        if (concede) begin
          mem_dir_d = dir_w;
          if (we_w) begin
            estado_d  = ESCRIBE;
            mem_we_d  = 1'b1;
            mem_din_d = dato_w;
          end else begin
            estado_d  = LEE_DIR;
          end
        end
      end
      ESCRIBE: begin
        estado_d = REPOSO;
        ack_w_d  = 1'b1;
      end
      LEE_DIR: begin
        // Hold the host address while the memory returns its data.
        estado_d  = LEE_DATO;
        mem_dir_d = mem_dir_q;
      end
      LEE_DATO: begin
        estado_d = REPOSO;
        dato_r_d = mem_dout;
        ack_w_d  = 1'b1;
      end
      default: estado_d = REPOSO;
    endcase

    // Video pipeline: address in n, memory address in n+1, data in n+2,
    // registered pixel in n+3. A slot taken by the host carries a 0 pixel.
    v_d          = {v_q[0], video_on};
    pix_d        = {pix_q[0], video_on && (estado_q == REPOSO)};
    vid_valido_d = v_q[1];
    dato_vid_d   = pix_q[1] ? mem_dout : '0;

    if (conflicto && (conflictos_q != 8'hFF)) begin
      conflictos_d = conflictos_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      estado_q     <= REPOSO;
      mem_dir_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_din_q    <= '0;
      ack_w_q      <= 1'b0;
      dato_r_q     <= '0;
      dato_vid_q   <= '0;
      vid_valido_q <= 1'b0;
      v_q          <= '0;
      pix_q        <= '0;
      conflictos_q <= '0;
    end else begin
      estado_q     <= estado_d;
      mem_dir_q    <= mem_dir_d;
      mem_we_q     <= mem_we_d;
      mem_din_q    <= mem_din_d;
      ack_w_q      <= ack_w_d;
      dato_r_q     <= dato_r_d;
      dato_vid_q   <= dato_vid_d;
      vid_valido_q <= vid_valido_d;
      v_q          <= v_d;
      pix_q        <= pix_d;
      conflictos_q <= conflictos_d;
    end
  end

  assign mem_dir    = mem_dir_q;
  assign mem_we     = mem_we_q;
  assign mem_din    = mem_din_q;
  assign ack_w      = ack_w_q;
  assign dato_r     = dato_r_q;
  assign dato_vid   = dato_vid_q;
  assign vid_valido = vid_valido_q;
  assign conflictos = conflictos_q;

endmodule
